// File: rtl/uart_reg_writer.sv
// UART byte receiver with a two-byte data/address decoder feeding a
// first-word fall-through write queue for the APU register file.
module uart_reg_writer #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [7:0]                    wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          seq_err,
  output logic                          overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

  logic            rx_s1, rx_s2;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            rx_stb, rx_stb_n, frame_err_n;
  logic            tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_stb    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_stb    <= rx_stb_n;
      frame_err <= frame_err_n;
    end
  end

  // cnt counts down to the next sample point; a sample is taken when it reaches 1
  assign tick = (cnt == CW'(1));

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_stb_n    = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s2) begin
          state_n = START;
          cnt_n   = CW'(DIV / 2);
        end
      end
      START: begin
        if (tick) begin
          if (rx_s2) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            cnt_n     = CW'(DIV);
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = {rx_s2, shreg[7:1]};
          cnt_n   = CW'(DIV);
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s2) begin
            rx_stb_n = 1'b1;
            state_n  = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic                  pend;
  logic [6:0]            pend_data;
  logic                  push_q;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [7:0]            push_data;
  logic [5:0]            addr_field;
  logic                  addr_oor;

  assign addr_field = shreg[6:1];
  assign addr_oor   = ((addr_field >> ADDR_WIDTH) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_data <= '0;
      push_q    <= 1'b0;
      push_addr <= '0;
      push_data <= '0;
      seq_err   <= 1'b0;
    end else begin
      push_q  <= 1'b0;
      seq_err <= 1'b0;
      if (rx_stb) begin
        if (!shreg[7]) begin
          pend      <= 1'b1;
          pend_data <= shreg[6:0];
        end else begin
          pend <= 1'b0;
          if (pend && !addr_oor) begin
            push_q    <= 1'b1;
            push_addr <= addr_field[ADDR_WIDTH-1:0];
            push_data <= {shreg[0], pend_data};
          end else begin
            seq_err <= 1'b1;
          end
        end
      end
    end
  end

  logic [PW:0]            wr_ptr, rd_ptr;
  logic [ADDR_WIDTH+7:0]  mem [FIFO_DEPTH];
  logic [ADDR_WIDTH+7:0]  head;
  logic                   empty, full, pop, accept;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_valid = ~empty;
  assign pop      = wr_valid & wr_ready;
  // a pop in the same cycle frees the slot, so a push into a full queue still lands
  assign accept   = push_q & (~full | pop);
  assign overflow = push_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[PW-1:0]] <= {push_addr, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  assign head       = mem[rd_ptr[PW-1:0]];
  assign wr_addr    = wr_valid ? head[ADDR_WIDTH+7:8] : '0;
  assign wr_data    = wr_valid ? head[7:0] : '0;
  assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_reg_writer.sv
// Bench for uart_reg_writer: three instances (default timing, 115200 baud,
// and a fast 4-bit-address instance for table vectors and random traffic).
module tb_uart_reg_writer;

  localparam int NDUT  = 3;
  localparam int DIV_D = 1250;
  localparam int DIV_F = 104;
  localparam int DIV_A = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rx     [NDUT];
  logic       ready  [NDUT];
  logic       rst_n  [NDUT];
  logic       valid  [NDUT];
  logic [5:0] addr   [NDUT];
  logic [7:0] data   [NDUT];
  logic [2:0] level  [NDUT];
  logic       ferr   [NDUT];
  logic       serr   [NDUT];
  logic       ovf    [NDUT];
  logic [3:0] addr_a;

  uart_reg_writer u_def (
    .clk(clk), .rst_n(rst_n[0]), .rx(rx[0]),
    .wr_valid(valid[0]), .wr_ready(ready[0]), .wr_addr(addr[0]), .wr_data(data[0]),
    .fifo_level(level[0]), .frame_err(ferr[0]), .seq_err(serr[0]), .overflow(ovf[0])
  );

  uart_reg_writer #(.CLK_HZ(12_000_000), .BAUD(115_200)) u_fast (
    .clk(clk), .rst_n(rst_n[1]), .rx(rx[1]),
    .wr_valid(valid[1]), .wr_ready(ready[1]), .wr_addr(addr[1]), .wr_data(data[1]),
    .fifo_level(level[1]), .frame_err(ferr[1]), .seq_err(serr[1]), .overflow(ovf[1])
  );

  uart_reg_writer #(.CLK_HZ(1_600_000), .BAUD(100_000), .ADDR_WIDTH(4)) u_a4 (
    .clk(clk), .rst_n(rst_n[2]), .rx(rx[2]),
    .wr_valid(valid[2]), .wr_ready(ready[2]), .wr_addr(addr_a), .wr_data(data[2]),
    .fifo_level(level[2]), .frame_err(ferr[2]), .seq_err(serr[2]), .overflow(ovf[2])
  );
  assign addr[2] = {2'b00, addr_a};

  int n_vec = 0;
  int n_fail = 0;
  int ferr_cnt [NDUT];
  int seq_cnt  [NDUT];
  int ovf_cnt  [NDUT];
  logic [13:0] obs0[$], obs1[$], obs2[$];

  // Observe every accepted handshake and every error pulse, mid-cycle.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (valid[d] && ready[d]) begin
        case (d)
          0: obs0.push_back({addr[d], data[d]});
          1: obs1.push_back({addr[d], data[d]});
          default: obs2.push_back({addr[d], data[d]});
        endcase
      end
      if (ferr[d]) ferr_cnt[d]++;
      if (serr[d]) seq_cnt[d]++;
      if (ovf[d])  ovf_cnt[d]++;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 95000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int d);
    case (d)
      0: return DIV_D;
      1: return DIV_F;
      default: return DIV_A;
    endcase
  endfunction

  function automatic int obs_size(input int d);
    case (d)
      0: return obs0.size();
      1: return obs1.size();
      default: return obs2.size();
    endcase
  endfunction

  task automatic get_obs(input int d, output bit ok, output logic [13:0] v);
    ok = 1'b0;
    v  = '0;
    case (d)
      0: if (obs0.size() > 0) begin v = obs0.pop_front(); ok = 1'b1; end
      1: if (obs1.size() > 0) begin v = obs1.pop_front(); ok = 1'b1; end
      default: if (obs2.size() > 0) begin v = obs2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic expect_write(input int d, input string name, input int a, input int dat);
    bit ok;
    logic [13:0] v;
    get_obs(d, ok, v);
    check({name, "_present"}, 32'(ok), 1);
    if (ok) begin
      check({name, "_addr"}, 32'(v[13:8]), a);
      check({name, "_data"}, 32'(v[7:0]), dat);
    end
  endtask

  // pop_at >= 0 raises ready for exactly one cycle, k cycles into the stop bit
  task automatic send_byte(input int d, input logic [7:0] b, input bit stop_ok, input int pop_at);
    int dv;
    dv = div_of(d);
    @(negedge clk);
    rx[d] = 1'b0;
    repeat (dv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[d] = b[i];
      repeat (dv) @(negedge clk);
    end
    rx[d] = stop_ok;
    for (int k = 0; k < dv; k++) begin
      if (pop_at >= 0 && k == pop_at)     ready[d] = 1'b1;
      if (pop_at >= 0 && k == pop_at + 1) ready[d] = 1'b0;
      @(negedge clk);
    end
    if (!stop_ok) begin
      rx[d] = 1'b1;
      repeat (dv) @(negedge clk);
    end
  endtask

  task automatic send_pair(input int d, input logic [7:0] b0, input logic [7:0] b1);
    send_byte(d, b0, 1'b1, -1);
    send_byte(d, b1, 1'b1, -1);
  endtask

  // Reference decoder: turns a byte stream into expected writes and error counts.
  bit          m_pend = 1'b0;
  int          m_pd = 0;
  int          exp_seq = 0;
  int          exp_ferr = 0;
  logic [13:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b, input bit ok);
    int a;
    if (!ok) begin
      exp_ferr++;
    end else if (b < 128) begin
      m_pend = 1'b1;
      m_pd   = int'(b) % 128;
    end else begin
      a = (int'(b) / 2) % 64;
      if (m_pend && a < 16) exp_q.push_back(14'(a * 256 + (int'(b) % 2) * 128 + m_pd));
      else                  exp_seq++;
      m_pend = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         wr;
    int         a;
    int         dat;
    int         seq;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] clr [8];
  bit         rnd_on;

  initial begin
    tbl[0] = '{8'h27, 8'h83, 1'b1, 1,  8'hA7, 0};
    tbl[1] = '{8'h7C, 8'h84, 1'b1, 2,  8'h7C, 0};
    tbl[2] = '{8'h12, 8'hA0, 1'b0, 0,  0,     1};
    tbl[3] = '{8'h12, 8'h9E, 1'b1, 15, 8'h12, 0};
    tbl[4] = '{8'h55, 8'hFF, 1'b0, 0,  0,     1};
    tbl[5] = '{8'h00, 8'h81, 1'b1, 0,  8'h80, 0};
    tbl[6] = '{8'h7F, 8'h9F, 1'b1, 15, 8'hFF, 0};
    clr = '{8'h00, 8'h91, 8'h00, 8'h92, 8'h00, 8'h94, 8'h00, 8'h96};

    for (int d = 0; d < NDUT; d++) begin
      rx[d] = 1'b1; ready[d] = 1'b0; rst_n[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_valid%0d", d), 32'(valid[d]), 0);
      check($sformatf("rst_addr%0d", d),  32'(addr[d]),  0);
      check($sformatf("rst_data%0d", d),  32'(data[d]),  0);
      check($sformatf("rst_level%0d", d), 32'(level[d]), 0);
    end
    check("rst_pulses", 32'({ferr[1], serr[1], ovf[1]}), 0);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    repeat (3) @(negedge clk);

    fork
      begin
        ready[0] = 1'b1;
        send_pair(0, 8'h27, 8'h83);
        repeat (4) @(negedge clk);
        expect_write(0, "def_basic", 1, 8'hA7);
        check("def_extra", 32'(obs_size(0)), 0);
      end
      begin
        int s0, f0, o0;
        // basic writes at 115200 baud
        ready[1] = 1'b1;
        send_pair(1, 8'h27, 8'h83);
        repeat (4) @(negedge clk);
        expect_write(1, "basic1", 1, 8'hA7);
        send_pair(1, 8'h7C, 8'h84);
        repeat (4) @(negedge clk);
        expect_write(1, "basic2", 2, 8'h7C);

        // full clear sequence held back, then drained without bubbles
        ready[1] = 1'b0;
        o0 = ovf_cnt[1];
        for (int i = 0; i < 8; i++) send_byte(1, clr[i], 1'b1, -1);
        repeat (4) @(negedge clk);
        #1;
        check("clr_level", 32'(level[1]), 4);
        check("clr_ovf", ovf_cnt[1] - o0, 0);
        @(negedge clk);
        ready[1] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("clr_level_after2", 32'(level[1]), 2);
        repeat (4) @(negedge clk);
        ready[1] = 1'b0;
        expect_write(1, "clr0", 8,  8'h80);
        expect_write(1, "clr1", 9,  8'h00);
        expect_write(1, "clr2", 10, 8'h00);
        expect_write(1, "clr3", 11, 8'h00);
        check("clr_extra", 32'(obs_size(1)), 0);

        // framing error, recovery, and address without pending data
        ready[1] = 1'b1;
        f0 = ferr_cnt[1];
        send_byte(1, 8'h3C, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("ferr_pulse", ferr_cnt[1] - f0, 1);
        check("ferr_nowrite", 32'(obs_size(1)), 0);
        send_pair(1, 8'h55, 8'h83);
        repeat (4) @(negedge clk);
        expect_write(1, "after_ferr", 1, 8'hD5);
        s0 = seq_cnt[1];
        send_byte(1, 8'h83, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("seq_nopend", seq_cnt[1] - s0, 1);
        check("seq_nowrite", 32'(obs_size(1)), 0);

        // overflow: fifth write is dropped
        ready[1] = 1'b0;
        o0 = ovf_cnt[1];
        for (int i = 1; i <= 5; i++) send_pair(1, 8'(i), 8'(129 + 2 * i));
        repeat (4) @(negedge clk);
        #1;
        check("ovf_pulse", ovf_cnt[1] - o0, 1);
        check("ovf_level", 32'(level[1]), 4);
        @(negedge clk);
        ready[1] = 1'b1;
        repeat (8) @(negedge clk);
        ready[1] = 1'b0;
        for (int i = 1; i <= 4; i++) expect_write(1, $sformatf("ovf_pop%0d", i), i, 128 + i);
        check("ovf_extra", 32'(obs_size(1)), 0);

        // full queue: push coincides with a single-cycle pop
        o0 = ovf_cnt[1];
        for (int i = 1; i <= 4; i++) send_pair(1, 8'(16 + i), 8'(129 + 2 * i));
        send_byte(1, 8'h20, 1'b1, -1);
        send_byte(1, 8'h8B, 1'b1, DIV_F / 2 + 4);
        repeat (4) @(negedge clk);
        #1;
        check("simul_ovf", ovf_cnt[1] - o0, 0);
        check("simul_level", 32'(level[1]), 4);
        @(negedge clk);
        ready[1] = 1'b1;
        repeat (8) @(negedge clk);
        ready[1] = 1'b0;
        for (int i = 1; i <= 4; i++) expect_write(1, $sformatf("simul_pop%0d", i), i, 144 + i);
        expect_write(1, "simul_new", 5, 8'hA0);
        check("simul_extra", 32'(obs_size(1)), 0);

        // reset in the middle of a data byte
        send_pair(1, 8'h27, 8'h83);
        repeat (4) @(negedge clk);
        #1;
        check("pre_rst_valid", 32'(valid[1]), 1);
        check("pre_rst_addr", 32'(addr[1]), 1);
        @(negedge clk);
        rx[1] = 1'b0;
        repeat (DIV_F) @(negedge clk);
        rx[1] = 1'b1;
        repeat (DIV_F) @(negedge clk);
        rx[1] = 1'b0;
        repeat (2 * DIV_F) @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check("midrst_valid", 32'(valid[1]), 0);
        check("midrst_addr",  32'(addr[1]),  0);
        check("midrst_data",  32'(data[1]),  0);
        check("midrst_level", 32'(level[1]), 0);
        check("midrst_pulses", 32'({ferr[1], serr[1], ovf[1]}), 0);
        @(negedge clk);
        rx[1] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (5) @(negedge clk);
        ready[1] = 1'b1;
        send_pair(1, 8'h08, 8'h82);
        repeat (4) @(negedge clk);
        expect_write(1, "post_rst", 1, 8'h08);
        check("post_rst_extra", 32'(obs_size(1)), 0);

        // one-cycle glitch is rejected, then a normal write still works
        s0 = seq_cnt[1];
        f0 = ferr_cnt[1];
        @(negedge clk);
        rx[1] = 1'b0;
        @(negedge clk);
        rx[1] = 1'b1;
        repeat (20 * DIV_F) @(negedge clk);
        check("glitch_nowrite", 32'(obs_size(1)), 0);
        check("glitch_seq", seq_cnt[1] - s0, 0);
        check("glitch_ferr", ferr_cnt[1] - f0, 0);
        send_pair(1, 8'h27, 8'h83);
        repeat (4) @(negedge clk);
        expect_write(1, "glitch_basic", 1, 8'hA7);

        // table vectors on the 4-bit address instance
        ready[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
          s0 = seq_cnt[2];
          send_pair(2, tbl[i].b0, tbl[i].b1);
          repeat (4) @(negedge clk);
          if (tbl[i].wr) expect_write(2, $sformatf("tbl%0d", i), tbl[i].a, tbl[i].dat);
          else           check($sformatf("tbl%0d_nowrite", i), 32'(obs_size(2)), 0);
          check($sformatf("tbl%0d_seq", i), seq_cnt[2] - s0, tbl[i].seq);
        end

        // random byte stream with random back-pressure against the model
        s0 = seq_cnt[2];
        f0 = ferr_cnt[2];
        o0 = ovf_cnt[2];
        rnd_on = 1'b1;
        fork
          begin
            for (int i = 0; i < 60; i++) begin
              logic [7:0] b;
              bit ok;
              if ($urandom_range(0, 1) == 0) b = {1'b0, 7'($urandom)};
              else b = {1'b1, 6'($urandom_range(0, 19)), 1'($urandom)};
              ok = ($urandom_range(0, 7) != 0);
              model_byte(b, ok);
              send_byte(2, b, ok, -1);
            end
            rnd_on = 1'b0;
          end
          begin
            while (rnd_on) begin
              @(negedge clk);
              ready[2] = 1'($urandom);
            end
          end
        join
        ready[2] = 1'b1;
        repeat (6 * DIV_A) @(negedge clk);
        check("rnd_count", 32'(obs_size(2)), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_size(2) > 0) begin
          bit ok;
          logic [13:0] v;
          logic [13:0] e;
          e = exp_q.pop_front();
          get_obs(2, ok, v);
          check("rnd_write", 32'(v), 32'(e));
        end
        check("rnd_seq", seq_cnt[2] - s0, exp_seq);
        check("rnd_ferr", ferr_cnt[2] - f0, exp_ferr);
        check("rnd_ovf", ovf_cnt[2] - o0, 0);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
